// File: rtl/term_pkg.sv
// Shared constants and enums for the serial terminal command scheduler.
package term_pkg;

  localparam logic [7:0] ASC_FF  = 8'h0C;
  localparam logic [7:0] ASC_SP  = 8'h20;
  localparam logic [7:0] ASC_DEL = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } sched_state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_PUT  = 2'd1,
    REQ_CLR  = 2'd2
  } req_kind_e;

endpackage

// File: rtl/term_classify.sv
// Combinational byte classifier: printable -> putchar, form feed -> clearhome, else drop.
module term_classify
  import term_pkg::*;
(
  input  logic [7:0] i_byte,
  output req_kind_e  o_kind_c
);

  always_comb begin
    o_kind_c = REQ_NONE;
    if (i_byte == ASC_FF)
      o_kind_c = REQ_CLR;
    else if ((i_byte >= ASC_SP) && (i_byte < ASC_DEL))
      o_kind_c = REQ_PUT;
  end

endmodule

// File: rtl/term_sched.sv
// Arbitrates UART bytes and button pulses onto the LCD controller request port.
// Optional echo of accepted bytes on the transmit stream: define TERM_SCHED_ECHO_EN.
module term_sched
  import term_pkg::*;
#(
  parameter logic [7:0]  BTN_CHAR = 8'h41,
  parameter int unsigned GUARD    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       i_btn_char,
  input  logic       i_btn_clear,
  output logic       o_putchar,
  output logic       o_clearhome,
  output logic [7:0] o_char,
  input  logic       i_busy,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic [7:0] o_drop_cnt
);

  localparam int unsigned CNT_W = (GUARD > 1) ? $clog2(GUARD) : 1;

  sched_state_e     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend_clear;
  logic             r_pend_char;
  logic             r_tready;
  logic             r_putchar;
  logic             r_clearhome;
  logic [7:0]       r_char;
  logic [7:0]       r_drop_cnt;

  req_kind_e w_kind;
  logic      w_in_idle;
  logic      w_accept;
  logic      w_sel_clear;
  logic      w_sel_byte;
  logic      w_sel_char;
  logic      w_drop;
  logic      w_pend_clear_nxt;
  logic      w_pend_char_nxt;
  logic      w_idle_nxt;
  logic      w_echo_full_nxt;

  term_classify u_classify (
    .i_byte   (s_axis_tdata),
    .o_kind_c (w_kind)
  );

  // r_tready is only ever high in IDLE with no clear pending, so a handshake is a selection.
  assign w_in_idle   = (r_state == ST_IDLE);
  assign w_accept    = s_axis_tvalid & r_tready;
  assign w_sel_clear = w_in_idle & r_pend_clear;
  assign w_sel_byte  = w_accept & (w_kind != REQ_NONE);
  assign w_drop      = w_accept & (w_kind == REQ_NONE);
  assign w_sel_char  = w_in_idle & ~r_pend_clear & ~w_accept & r_pend_char;

  assign w_pend_clear_nxt = i_btn_clear | (r_pend_clear & ~w_sel_clear);
  assign w_pend_char_nxt  = i_btn_char  | (r_pend_char  & ~w_sel_char);
  assign w_idle_nxt = (w_in_idle & ~(w_sel_clear | w_sel_byte | w_sel_char))
                    | ((r_state == ST_WAIT) & ~i_busy);

`ifdef TERM_SCHED_ECHO_EN
  logic       r_m_tvalid;
  logic [7:0] r_m_tdata;

  // One-entry echo register; only loads when empty because acceptance requires it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= 8'h00;
    end else if (w_sel_byte) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= s_axis_tdata;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign w_echo_full_nxt = w_sel_byte | (r_m_tvalid & ~m_axis_tready);
  assign m_axis_tvalid   = r_m_tvalid;
  assign m_axis_tdata    = r_m_tdata;
`else
  logic w_unused_tready;
  assign w_unused_tready = m_axis_tready;
  assign w_echo_full_nxt = 1'b0;
  assign m_axis_tvalid   = 1'b0;
  assign m_axis_tdata    = 8'h00;
`endif

  // Scheduler FSM; request pulses are raised on entry to ISSUE and last that one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pend_clear <= 1'b0;
      r_pend_char  <= 1'b0;
      r_tready     <= 1'b0;
      r_putchar    <= 1'b0;
      r_clearhome  <= 1'b0;
      r_char       <= 8'h00;
      r_drop_cnt   <= 8'h00;
    end else begin
      r_pend_clear <= w_pend_clear_nxt;
      r_pend_char  <= w_pend_char_nxt;
      r_tready     <= w_idle_nxt & ~w_pend_clear_nxt & ~w_echo_full_nxt;
      r_putchar    <= 1'b0;
      r_clearhome  <= 1'b0;
      if (w_drop && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;

      case (r_state)
        ST_IDLE: begin
          if (w_sel_clear) begin
            r_clearhome <= 1'b1;
            r_state     <= ST_ISSUE;
          end else if (w_sel_byte) begin
            if (w_kind == REQ_CLR) begin
              r_clearhome <= 1'b1;
            end else begin
              r_putchar <= 1'b1;
              r_char    <= s_axis_tdata;
            end
            r_state <= ST_ISSUE;
          end else if (w_sel_char) begin
            r_putchar <= 1'b1;
            r_char    <= BTN_CHAR;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_GUARD;
        end
        ST_GUARD: begin
          if (r_cnt == CNT_W'(GUARD - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (!i_busy)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_tready = r_tready;
  assign o_putchar     = r_putchar;
  assign o_clearhome   = r_clearhome;
  assign o_char        = r_char;
  assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_term_sched.sv
// Directed self-checking bench for term_sched (echo scenario under TERM_SCHED_ECHO_EN).
module tb_term_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       i_btn_char = 1'b0;
  logic       i_btn_clear = 1'b0;
  logic       o_putchar;
  logic       o_clearhome;
  logic [7:0] o_char;
  logic       i_busy = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic [7:0] o_drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [1:0] log_kind[$];
  logic [7:0] log_char[$];

  term_sched #(.BTN_CHAR(8'h41), .GUARD(2)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .i_btn_char    (i_btn_char),
    .i_btn_clear   (i_btn_clear),
    .o_putchar     (o_putchar),
    .o_clearhome   (o_clearhome),
    .o_char        (o_char),
    .i_busy        (i_busy),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .o_drop_cnt    (o_drop_cnt)
  );

  always #5 clk = ~clk;

  // Request log: kind 1 = putchar, 2 = clearhome.
  always @(negedge clk) begin
    if (o_putchar) begin
      log_kind.push_back(2'd1);
      log_char.push_back(o_char);
    end
    if (o_clearhome) begin
      log_kind.push_back(2'd2);
      log_char.push_back(o_char);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout byte=%h not accepted in 200 cycles", b);
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic clear_log();
    log_kind.delete();
    log_char.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got=%b exp=0", s_axis_tready); end
    checks++; if (o_putchar !== 1'b0) begin errors++; $display("FAIL rst_putchar got=%b exp=0", o_putchar); end
    checks++; if (o_clearhome !== 1'b0) begin errors++; $display("FAIL rst_clearhome got=%b exp=0", o_clearhome); end
    checks++; if (o_char !== 8'h00) begin errors++; $display("FAIL rst_char got=%h exp=00", o_char); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL rst_mdata got=%h exp=00", m_axis_tdata); end
    checks++; if (o_drop_cnt !== 8'h00) begin errors++; $display("FAIL rst_drop got=%h exp=00", o_drop_cnt); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready got=%b exp=1", s_axis_tready); end
    wait_cycles(1);
  endtask

  task automatic test_putchar();
    bit low_ok;
    clear_log();
    send_byte(8'h48);
    @(negedge clk);
    checks++; if (o_putchar !== 1'b1 || o_char !== 8'h48) begin errors++; $display("FAIL put_pulse got=%b/%h exp=1/48", o_putchar, o_char); end
    wait_cycles(2);
    i_busy = 1'b1;
    low_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (s_axis_tready !== 1'b0) low_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    checks++; if (low_ok !== 1'b1) begin errors++; $display("FAIL put_tready_busy got=high exp=low"); end
    i_busy = 1'b0;
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL put_tready_fall got=%b exp=0", s_axis_tready); end
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL put_tready_ret got=%b exp=1", s_axis_tready); end
    checks++; if (log_kind.size() !== 1) begin errors++; $display("FAIL put_count got=%0d exp=1", log_kind.size()); end
    else if (log_kind[0] !== 2'd1 || log_char[0] !== 8'h48) begin checks++; errors++; $display("FAIL put_log got=%0d/%h exp=1/48", log_kind[0], log_char[0]); end
    checks++; if (o_char !== 8'h48) begin errors++; $display("FAIL put_char_hold got=%h exp=48", o_char); end
    wait_cycles(1);
  endtask

  task automatic test_clear();
    clear_log();
    send_byte(8'h0C);
    @(negedge clk);
    checks++; if (o_clearhome !== 1'b1 || o_putchar !== 1'b0) begin errors++; $display("FAIL clr_pulse got=%b/%b exp=1/0", o_clearhome, o_putchar); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL clr_early_ready got=%b exp=0", s_axis_tready); end
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL clr_ready_lat got=%b exp=1", s_axis_tready); end
    wait_cycles(4);
    checks++; if (log_kind.size() !== 1) begin errors++; $display("FAIL clr_count got=%0d exp=1", log_kind.size()); end
    else if (log_kind[0] !== 2'd2) begin checks++; errors++; $display("FAIL clr_kind got=%0d exp=2", log_kind[0]); end
  endtask

  task automatic test_drop();
    clear_log();
    send_byte(8'h07);
    send_byte(8'h1B);
    send_byte(8'h80);
    wait_cycles(3);
    checks++; if (o_drop_cnt !== 8'd3) begin errors++; $display("FAIL drop_cnt3 got=%h exp=03", o_drop_cnt); end
    for (int i = 0; i < 300; i++) send_byte(8'h01);
    wait_cycles(3);
    checks++; if (o_drop_cnt !== 8'hFF) begin errors++; $display("FAIL drop_sat got=%h exp=FF", o_drop_cnt); end
    checks++; if (log_kind.size() !== 0) begin errors++; $display("FAIL drop_pulses got=%0d exp=0", log_kind.size()); end
  endtask

  task automatic test_simultaneous();
    clear_log();
    send_byte(8'h61);
    i_busy = 1'b1;
    wait_cycles(5);
    i_btn_clear   = 1'b1;
    i_btn_char    = 1'b1;
    s_axis_tdata  = 8'h5A;
    s_axis_tvalid = 1'b1;
    wait_cycles(1);
    i_btn_clear = 1'b0;
    i_btn_char  = 1'b0;
    wait_cycles(3);
    i_busy = 1'b0;
    for (int i = 0; i < 300 && log_kind.size() < 4; i++) begin
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) begin
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
      end
    end
    s_axis_tvalid = 1'b0;
    wait_cycles(10);
    checks++; if (log_kind.size() !== 4) begin errors++; $display("FAIL sim_count got=%0d exp=4", log_kind.size()); end
    else begin
      checks++; if (log_kind[1] !== 2'd2) begin errors++; $display("FAIL sim_first got=%0d exp=2", log_kind[1]); end
      checks++; if (log_kind[2] !== 2'd1 || log_char[2] !== 8'h5A) begin errors++; $display("FAIL sim_second got=%0d/%h exp=1/5A", log_kind[2], log_char[2]); end
      checks++; if (log_kind[3] !== 2'd1 || log_char[3] !== 8'h41) begin errors++; $display("FAIL sim_third got=%0d/%h exp=1/41", log_kind[3], log_char[3]); end
    end
  endtask

`ifdef TERM_SCHED_ECHO_EN
  task automatic test_echo();
    bit held_ok;
    bit seen;
    clear_log();
    m_axis_tready = 1'b0;
    send_byte(8'h31);
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h31) begin errors++; $display("FAIL echo_first got=%b/%h exp=1/31", m_axis_tvalid, m_axis_tdata); end
    wait_cycles(1);
    s_axis_tdata  = 8'h32;
    s_axis_tvalid = 1'b1;
    held_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h31) held_ok = 1'b0;
    end
    checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL echo_hold got=blocked_broken exp=held_31"); end
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    @(posedge clk);
    #1 m_axis_tready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) begin
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
        @(negedge clk);
        seen = 1'b1;
      end
    end
    s_axis_tvalid = 1'b0;
    checks++; if (!seen || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h32) begin errors++; $display("FAIL echo_second got=%b/%h exp=1/32", m_axis_tvalid, m_axis_tdata); end
    m_axis_tready = 1'b1;
    wait_cycles(10);
    checks++; if (log_kind.size() !== 2) begin errors++; $display("FAIL echo_puts got=%0d exp=2", log_kind.size()); end
    else if (log_char[0] !== 8'h31 || log_char[1] !== 8'h32) begin checks++; errors++; $display("FAIL echo_order got=%h,%h exp=31,32", log_char[0], log_char[1]); end
    m_axis_tready = 1'b0;
  endtask
`else
  task automatic test_echo();
    m_axis_tready = 1'b1;
    send_byte(8'h33);
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00) begin errors++; $display("FAIL noecho got=%b/%h exp=0/00", m_axis_tvalid, m_axis_tdata); end
    m_axis_tready = 1'b0;
    wait_cycles(8);
  endtask
`endif

  task automatic test_reset_mid();
    clear_log();
    send_byte(8'h50);
    i_busy = 1'b1;
    wait_cycles(5);
    i_btn_char = 1'b1;
    wait_cycles(1);
    i_btn_char = 1'b0;
    wait_cycles(2);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (o_char !== 8'h00 || o_drop_cnt !== 8'h00 || s_axis_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_vals got=%h/%h/%b exp=00/00/0", o_char, o_drop_cnt, s_axis_tready); end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    i_busy = 1'b0;
    wait_cycles(30);
    checks++; if (log_kind.size() !== 1) begin errors++; $display("FAIL mid_rst_pulses got=%0d exp=1", log_kind.size()); end
    checks++; if (s_axis_tready !== 1'b1 || o_char !== 8'h00) begin errors++; $display("FAIL mid_rst_idle got=%b/%h exp=1/00", s_axis_tready, o_char); end
  endtask

  initial begin
    test_reset();
    test_putchar();
    test_clear();
    test_drop();
    test_simultaneous();
    test_echo();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/term_sched.md
# term_sched

Command scheduler between the serial link, the two push-buttons and the text-mode LCD controller. It accepts received bytes from the UART receive stream and one-tick button pulses, arbitrates them onto the controller's single putchar/clearhome request port, and waits for the controller's busy flag between requests. It can optionally echo accepted bytes back on the UART transmit stream. It replaces the direct button-to-controller wiring in the serial terminal top level.

## Interface
- BTN_CHAR, 8'h41, character issued by the putchar button
- GUARD, 2, cycles after a request pulse during which i_busy is ignored (≥1)
- i_clk  in  1  system clock (12 MHz domain); one clock only
- i_rst_n  in  1  asynchronous, active-low reset
- s_axis_tdata  in  8  received byte
- s_axis_tvalid  in  1  received byte valid
- s_axis_tready  out  1  byte accepted when valid&ready
- i_btn_char  in  1  one-tick pulse: putchar BTN_CHAR
- i_btn_clear  in  1  one-tick pulse: clearhome
- o_putchar  out  1  one-tick putchar request to controller
- o_clearhome  out  1  one-tick clearhome request to controller
- o_char  out  8  character for putchar, stable from pulse until next request
- i_busy  in  1  controller busy
- m_axis_tdata  out  8  echo byte
- m_axis_tvalid  out  1  echo valid
- m_axis_tready  in  1  echo accepted
- o_drop_cnt  out  8  saturating count of dropped non-printable bytes

## Operation
- Byte classes: 0x20–0x7E printable → putchar; 0x0C (FF) → clearhome; everything else dropped, o_drop_cnt += 1, saturating at 0xFF.
- Button pulses latch into pend_clear / pend_char flags; a repeated pulse while its flag is already set is absorbed (no count).
- FSM states: IDLE, ISSUE, GUARD, WAIT.
  - IDLE: select by fixed priority pend_clear > UART byte > pend_char. Selection clears the flag, or accepts the byte (s_axis_tready=1 that cycle). A dropped byte is accepted and counted; the FSM stays in IDLE. On any selection → ISSUE.
  - ISSUE: drive o_putchar or o_clearhome high for exactly one cycle; load o_char (putchar only) → GUARD.
  - GUARD: count GUARD cycles, ignoring i_busy → WAIT.
  - WAIT: stay while i_busy=1; on i_busy=0 → IDLE.
- s_axis_tready is high only in IDLE, when no pend_clear is set, and, with echo built in, when the echo register is empty.
- Simultaneous i_btn_clear and i_btn_char in one cycle: both latch; clear is served first.
- Button pulses arriving in any state latch and are never lost.
- Reset mid-operation: all state returns to reset values immediately. Pending flags are cleared and any held echo byte is discarded.

## Timing
- Reset values: s_axis_tready=0, o_putchar=0, o_clearhome=0, o_char=8'h00, m_axis_tvalid=0, m_axis_tdata=8'h00, o_drop_cnt=0, FSM=IDLE, flags clear.
- Request latency: byte accepted in cycle N (IDLE) → pulse in N+1 → earliest next acceptance in N+2+GUARD+1 if i_busy is already low.
- A button pulse in IDLE with nothing pending: flag set at edge N, selected at N+1, pulse at N+2.
- Minimum spacing between request pulses: GUARD+3 cycles.
- All outputs are registered.

## Configuration
- TERM_SCHED_ECHO_EN defined: every accepted printable or FF byte is copied into a one-entry echo register. m_axis_tvalid rises the cycle after acceptance and holds, with data stable, until m_axis_tready. A full register blocks s_axis_tready. Button requests are never echoed.
- Undefined: m_axis_tvalid and m_axis_tdata are tied to 0, the echo register is absent, and m_axis_tready is ignored.

## Structure
- Shared package term_pkg: ASCII constants (ASC_FF=8'h0C, ASC_SP=8'h20, ASC_DEL=8'h7F), sched state enum, request-kind enum {REQ_NONE, REQ_PUT, REQ_CLR}.
- One natural sub-module, term_classify: combinational byte → request kind. All other logic is flat.

## Test plan
- Byte 0x48 with i_busy rising 2 cycles after the pulse and held 20 cycles → one o_putchar with o_char=0x48. s_axis_tready stays low until i_busy falls.
- Byte 0x0C → one o_clearhome pulse; o_putchar stays 0.
- Bytes 0x07, 0x1B, 0x80 → no pulses; o_drop_cnt=3. Then 300 bytes of 0x01 → o_drop_cnt=0xFF.
- i_btn_clear and i_btn_char in the same cycle while a UART byte 0x5A is valid → order: clearhome, putchar 0x5A, putchar 0x41.
- With TERM_SCHED_ECHO_EN and m_axis_tready=0: bytes 0x31, 0x32 → first echoed and held with m_axis_tvalid=1. The second is not accepted until m_axis_tready pulses, then it is echoed in order.
- i_rst_n low for 1 cycle during WAIT with pend_char set → all outputs at reset values, flag lost, no further pulse until new stimulus.
